// File: rtl/vip_frame_cfg_ctrl_if.sv
// ---------------------------------------------------------------------------
// vip_frame_cfg_ctrl_if
// Groups the video timing, host configuration and status signals of the
// frame configuration controller.
//   master : the side that drives video timing and host config (source/host)
//   slave  : the controller itself
// Signals
//   per_frame_vsync/href/clken : pipeline input timing (vsync high = frame)
//   cfg_wr_en, cfg_mode, cfg_threshold : host config write strobe + payload
//   err_clr                    : strobe clearing the sticky error flags
//   Sobel_Threshold, out_sel   : active (frame-committed) settings
//   cfg_pending                : shadow holds an uncommitted write
//   frame_cnt                  : completed frames, wrapping
//   size_err, timeout_err      : sticky error flags
// ---------------------------------------------------------------------------
interface vip_frame_cfg_ctrl_if;
  logic        per_frame_vsync;
  logic        per_frame_href;
  logic        per_frame_clken;
  logic        cfg_wr_en;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_threshold;
  logic        err_clr;
  logic [7:0]  Sobel_Threshold;
  logic [1:0]  out_sel;
  logic        cfg_pending;
  logic [15:0] frame_cnt;
  logic        size_err;
  logic        timeout_err;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    output cfg_wr_en, cfg_mode, cfg_threshold, err_clr,
    input  Sobel_Threshold, out_sel, cfg_pending, frame_cnt,
    input  size_err, timeout_err
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken,
    input  cfg_wr_en, cfg_mode, cfg_threshold, err_clr,
    output Sobel_Threshold, out_sel, cfg_pending, frame_cnt,
    output size_err, timeout_err
  );
endinterface

// File: rtl/vip_frame_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// vip_frame_cfg_ctrl
// Frame-synchronous controller for the RGB->Y->Sobel->Erosion pipeline.
// Host writes land in a shadow register and are committed to the active
// settings only at start-of-frame, so a frame never sees mixed settings.
// Also counts frames and checks line/frame geometry and vsync duration.
// Ports
//   clk   : pixel clock
//   rst_n : synchronous active-low reset
//   bus   : vip_frame_cfg_ctrl_if.slave (timing in, config in, status out)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module vip_frame_cfg_ctrl #(
  parameter logic [11:0] IMG_HDISP   = 12'd1280,
  parameter logic [11:0] IMG_VDISP   = 12'd720,
  parameter logic [23:0] TIMEOUT_CYC = 24'd2000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vip_frame_cfg_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_SYNC     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_t;

  localparam logic [7:0] THR_RST = 8'd40;
  localparam logic [1:0] SEL_RST = 2'd1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    logic [11:0] r;
    if (v == 12'hFFF) begin
      r = v;
    end else begin
      r = v + 12'd1;
    end
    return r;
  endfunction

  state_t      state_r;
  logic        vsync_d_r;
  logic        href_d_r;
  logic [11:0] pix_cnt_r;
  logic [11:0] line_cnt_r;
  logic [23:0] tmo_cnt_r;
  logic [15:0] frame_cnt_r;
  logic [7:0]  shadow_thr_r;
  logic [1:0]  shadow_sel_r;
  logic [7:0]  thr_r;
  logic [1:0]  sel_r;
  logic        pending_r;
  logic        size_err_r;
  logic        timeout_err_r;

  logic        sof_s;
  logic        eof_s;
  logic        eol_s;
  logic        in_active_s;
  logic        cfg_load_s;
  logic        commit_s;
  logic [11:0] line_next_s;
  logic        size_set_s;
  logic        timeout_hit_s;

  assign sof_s       = bus.per_frame_vsync & ~vsync_d_r;
  assign eof_s       = ~bus.per_frame_vsync & vsync_d_r;
  assign eol_s       = ~bus.per_frame_href & href_d_r;
  assign in_active_s = (state_r == ST_ACTIVE);

  // Mode 3 is reserved: the whole write (threshold too) is discarded.
  assign cfg_load_s  = bus.cfg_wr_en & (bus.cfg_mode != 2'd3);
  assign commit_s    = (state_r == ST_WAIT_SOF) & sof_s & pending_r;

  // Line count as it stands after this cycle, so an eol coinciding with
  // eof is included in the frame-height check.
  assign line_next_s = eol_s ? sat_inc12(line_cnt_r) : line_cnt_r;

  // Geometry checks and timeout decision for the current cycle.
  always_comb begin
    size_set_s    = 1'b0;
    timeout_hit_s = 1'b0;
    if (in_active_s) begin
      size_set_s = (eol_s & (pix_cnt_r != IMG_HDISP)) |
                   (eof_s & (line_next_s != IMG_VDISP));
      // A regular end-of-frame takes precedence over an expiring timer.
      timeout_hit_s = ~eof_s & (tmo_cnt_r == (TIMEOUT_CYC - 24'd1));
    end else begin
      size_set_s    = 1'b0;
      timeout_hit_s = 1'b0;
    end
  end

  // One-cycle delayed timing copies for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_d_r <= 1'b0;
      href_d_r  <= 1'b0;
    end else begin
      vsync_d_r <= bus.per_frame_vsync;
      href_d_r  <= bus.per_frame_href;
    end
  end

  // Frame tracking FSM with pixel/line/timeout counters and frame counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_SYNC;
      pix_cnt_r   <= 12'd0;
      line_cnt_r  <= 12'd0;
      tmo_cnt_r   <= 24'd0;
      frame_cnt_r <= 16'd0;
    end else begin
      case (state_r)
        // Out of reset or after a timeout we may be mid-frame; wait for a
        // blanking gap so a partial frame is never counted.
        ST_SYNC: begin
          if (!bus.per_frame_vsync) begin
            state_r <= ST_WAIT_SOF;
          end
        end
        ST_WAIT_SOF: begin
          if (sof_s) begin
            state_r    <= ST_ACTIVE;
            pix_cnt_r  <= 12'd0;
            line_cnt_r <= 12'd0;
            tmo_cnt_r  <= 24'd0;
          end
        end
        ST_ACTIVE: begin
          if (eol_s) begin
            pix_cnt_r <= 12'd0;
          end else if (bus.per_frame_href && bus.per_frame_clken) begin
            pix_cnt_r <= sat_inc12(pix_cnt_r);
          end
          line_cnt_r <= line_next_s;
          tmo_cnt_r  <= tmo_cnt_r + 24'd1;
          if (eof_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
            state_r     <= ST_WAIT_SOF;
          end else if (timeout_hit_s) begin
            state_r <= ST_SYNC;
          end
        end
        default: begin
          state_r <= ST_SYNC;
        end
      endcase
    end
  end

  // Shadow/active configuration registers and pending flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_thr_r <= THR_RST;
      shadow_sel_r <= SEL_RST;
      thr_r        <= THR_RST;
      sel_r        <= SEL_RST;
      pending_r    <= 1'b0;
    end else begin
      // Commit reads the old shadow, so a write in the sof cycle is kept
      // for the following frame.
      if (commit_s) begin
        thr_r <= shadow_thr_r;
        sel_r <= shadow_sel_r;
      end
      if (cfg_load_s) begin
        shadow_thr_r <= bus.cfg_threshold;
        shadow_sel_r <= bus.cfg_mode;
        pending_r    <= 1'b1;
      end else if (commit_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      size_err_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      size_err_r    <= size_set_s | (size_err_r & ~bus.err_clr);
      timeout_err_r <= timeout_hit_s | (timeout_err_r & ~bus.err_clr);
    end
  end

  assign bus.Sobel_Threshold = thr_r;
  assign bus.out_sel         = sel_r;
  assign bus.cfg_pending     = pending_r;
  assign bus.frame_cnt       = frame_cnt_r;
  assign bus.size_err        = size_err_r;
  assign bus.timeout_err     = timeout_err_r;

endmodule

// File: tb/tb_vip_frame_cfg_ctrl.sv
// Bench for vip_frame_cfg_ctrl: directed scenarios with literal expectations,
// then randomized frames, all checked every cycle against a frame-level model.
module tb_vip_frame_cfg_ctrl;
  localparam logic [11:0] HD  = 12'd8;
  localparam logic [11:0] VD  = 12'd4;
  localparam logic [23:0] TMO = 24'd100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vip_frame_cfg_ctrl_if vif();

  vip_frame_cfg_ctrl #(
    .IMG_HDISP(HD),
    .IMG_VDISP(VD),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(vif.slave)
  );

  // bench-side stimulus values
  logic       b_rst_n = 1'b0;
  logic       b_vs = 1'b0, b_href = 1'b0, b_clken = 1'b0;
  logic       b_wr = 1'b0, b_clr = 1'b0;
  logic [1:0] b_mode = 2'd0;
  logic [7:0] b_thr = 8'd0;
  bit         rnd_on = 1'b0;
  bit         cmp_en = 1'b0;

  int n_checks = 0;
  int n_errs   = 0;

  // model state
  int m_thr, m_sel, m_sh_thr, m_sh_sel, m_pend, m_fcnt, m_size, m_tmo;
  int m_pix, m_lines, m_age;
  bit m_vs_prev, m_href_prev, m_armed, m_in_frame;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: what the outputs must be after this cycle's inputs.
  task automatic model_step();
    bit sof, eof, eol, commit, set_size, set_tmo;
    if (!b_rst_n) begin
      m_thr = 40; m_sel = 1; m_sh_thr = 40; m_sh_sel = 1; m_pend = 0;
      m_fcnt = 0; m_size = 0; m_tmo = 0; m_pix = 0; m_lines = 0; m_age = 0;
      m_vs_prev = 0; m_href_prev = 0; m_armed = 0; m_in_frame = 0;
    end else begin
      sof = b_vs && !m_vs_prev;
      eof = !b_vs && m_vs_prev;
      eol = !b_href && m_href_prev;
      commit = 0; set_size = 0; set_tmo = 0;
      if (m_in_frame) begin
        if (eol) begin
          if (m_pix != int'(HD)) set_size = 1;
          m_lines = (m_lines < 4095) ? m_lines + 1 : 4095;
          m_pix = 0;
        end else if (b_href && b_clken) begin
          m_pix = (m_pix < 4095) ? m_pix + 1 : 4095;
        end
        if (eof) begin
          m_fcnt = (m_fcnt + 1) % 65536;
          if (m_lines != int'(VD)) set_size = 1;
          m_in_frame = 0;
        end else if (m_age == int'(TMO) - 1) begin
          set_tmo = 1;
          m_in_frame = 0;
          m_armed = 0;
        end
        m_age++;
      end else if (m_armed) begin
        if (sof) begin
          m_in_frame = 1; m_pix = 0; m_lines = 0; m_age = 0;
          commit = (m_pend != 0);
        end
      end else if (!b_vs) begin
        m_armed = 1;
      end
      if (commit) begin
        m_thr = m_sh_thr;
        m_sel = m_sh_sel;
      end
      if (b_wr && b_mode != 2'd3) begin
        m_sh_thr = b_thr; m_sh_sel = b_mode; m_pend = 1;
      end else if (commit) begin
        m_pend = 0;
      end
      m_size = ((m_size != 0 && !b_clr) || set_size) ? 1 : 0;
      m_tmo  = ((m_tmo  != 0 && !b_clr) || set_tmo)  ? 1 : 0;
      m_vs_prev = b_vs;
      m_href_prev = b_href;
    end
  endtask

  task automatic rnd_stim();
    if ($urandom_range(0, 7) == 0) begin
      b_wr = 1'b1;
      b_mode = 2'($urandom_range(0, 3));
      b_thr = 8'($urandom_range(0, 255));
    end
    if ($urandom_range(0, 15) == 0) b_clr = 1'b1;
  endtask

  // One clock: drive at negedge, advance model, return just after posedge.
  task automatic tick();
    @(negedge clk);
    if (rnd_on) rnd_stim();
    rst_n = b_rst_n;
    vif.per_frame_vsync = b_vs;
    vif.per_frame_href  = b_href;
    vif.per_frame_clken = b_clken;
    vif.cfg_wr_en       = b_wr;
    vif.cfg_mode        = b_mode;
    vif.cfg_threshold   = b_thr;
    vif.err_clr         = b_clr;
    model_step();
    b_wr = 1'b0;
    b_clr = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic send_line(input int npix, input bit gaps, input bit end_vs, input bit clr_eol);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        b_href = 1'b1; b_clken = 1'b0; tick();
      end
      b_href = 1'b1; b_clken = 1'b1; tick();
    end
    b_href = 1'b0; b_clken = 1'b0; b_vs = end_vs;
    if (clr_eol) b_clr = 1'b1;
    tick();
  endtask

  task automatic frame_begin();
    b_vs = 1'b1; b_href = 1'b0; b_clken = 1'b0; tick();
  endtask

  task automatic frame_end();
    b_vs = 1'b0; tick(); tick();
  endtask

  task automatic good_lines(input int n);
    for (int i = 0; i < n; i++) send_line(int'(HD), 1'b0, 1'b1, 1'b0);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("thr",       vif.Sobel_Threshold, m_thr);
      chk("out_sel",   vif.out_sel,         m_sel);
      chk("pending",   vif.cfg_pending,     m_pend);
      chk("frame_cnt", vif.frame_cnt,       m_fcnt);
      chk("size_err",  vif.size_err,        m_size);
      chk("tmo_err",   vif.timeout_err,     m_tmo);
    end
  end

  initial begin
    vif.per_frame_vsync = 1'b0; vif.per_frame_href = 1'b0; vif.per_frame_clken = 1'b0;
    vif.cfg_wr_en = 1'b0; vif.cfg_mode = 2'd0; vif.cfg_threshold = 8'd0; vif.err_clr = 1'b0;

    // T1 reset
    b_rst_n = 1'b0;
    repeat (3) tick();
    b_rst_n = 1'b1; tick();
    chk("t1_thr", vif.Sobel_Threshold, 40);
    chk("t1_sel", vif.out_sel, 1);
    chk("t1_fcnt", vif.frame_cnt, 0);
    chk("t1_size", vif.size_err, 0);
    chk("t1_tmo", vif.timeout_err, 0);
    chk("t1_pend", vif.cfg_pending, 0);
    tick();

    // T2 commit at next sof
    frame_begin();
    b_wr = 1'b1; b_mode = 2'd2; b_thr = 8'd80; tick();
    chk("t2_thr_hold", vif.Sobel_Threshold, 40);
    chk("t2_sel_hold", vif.out_sel, 1);
    chk("t2_pend", vif.cfg_pending, 1);
    good_lines(4);
    frame_end();
    chk("t2_fcnt", vif.frame_cnt, 1);
    chk("t2_size", vif.size_err, 0);
    frame_begin();
    chk("t2_thr", vif.Sobel_Threshold, 80);
    chk("t2_sel", vif.out_sel, 2);
    chk("t2_pend_clr", vif.cfg_pending, 0);

    // T3 short line; clear coinciding with the error loses
    send_line(7, 1'b0, 1'b1, 1'b1);
    chk("t3_size_set", vif.size_err, 1);
    good_lines(3);
    frame_end();
    chk("t3_fcnt", vif.frame_cnt, 2);
    b_clr = 1'b1; tick();
    chk("t3_size_clr", vif.size_err, 0);

    // T4 write racing sof
    b_wr = 1'b1; b_mode = 2'd1; b_thr = 8'd60; tick();
    b_vs = 1'b1; b_wr = 1'b1; b_mode = 2'd0; b_thr = 8'd90; tick();
    chk("t4_thr60", vif.Sobel_Threshold, 60);
    chk("t4_sel1", vif.out_sel, 1);
    chk("t4_pend", vif.cfg_pending, 1);
    good_lines(4);
    frame_end();
    frame_begin();
    chk("t4_thr90", vif.Sobel_Threshold, 90);
    chk("t4_sel0", vif.out_sel, 0);
    good_lines(4);
    frame_end();

    // reserved mode write is dropped entirely
    b_wr = 1'b1; b_mode = 2'd3; b_thr = 8'd200; tick();
    chk("m3_pend", vif.cfg_pending, 0);
    frame_begin();
    chk("m3_thr", vif.Sobel_Threshold, 90);
    good_lines(4);
    frame_end();
    chk("m3_fcnt", vif.frame_cnt, 5);

    // T5 vsync stuck high
    b_vs = 1'b1;
    repeat (150) tick();
    chk("t5_tmo", vif.timeout_err, 1);
    chk("t5_fcnt", vif.frame_cnt, 5);
    frame_end();
    chk("t5_fcnt_sync", vif.frame_cnt, 5);
    frame_begin(); good_lines(4); frame_end();
    chk("t5_fcnt_next", vif.frame_cnt, 6);
    chk("t5_tmo_sticky", vif.timeout_err, 1);
    b_clr = 1'b1; tick();
    chk("t5_tmo_clr", vif.timeout_err, 0);

    // T6 reset released mid-frame
    frame_begin(); good_lines(1);
    b_rst_n = 1'b0; tick();
    b_rst_n = 1'b1;
    good_lines(2);
    frame_end();
    chk("t6_fcnt_partial", vif.frame_cnt, 0);
    chk("t6_size", vif.size_err, 0);
    frame_begin(); good_lines(4); frame_end();
    chk("t6_fcnt", vif.frame_cnt, 1);
    chk("t6_size_ok", vif.size_err, 0);

    // randomized frames
    rnd_on = 1'b1;
    for (int f = 0; f < 60; f++) begin
      int nl;
      bit merge;
      b_vs = 1'b0; b_href = 1'b0; b_clken = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      frame_begin();
      if ($urandom_range(0, 14) == 0) begin
        repeat (110) tick();
      end else begin
        nl = $urandom_range(3, 4);
        merge = ($urandom_range(0, 1) == 1);
        for (int l = 0; l < nl; l++) begin
          int np;
          bit last;
          last = (l == nl - 1);
          np = ($urandom_range(0, 5) == 0) ? int'($urandom_range(7, 9)) : int'(HD);
          if (l == 1 && $urandom_range(0, 19) == 0) begin
            b_rst_n = 1'b0; tick(); b_rst_n = 1'b1;
          end
          send_line(np, 1'b1, !(last && merge), 1'b0);
        end
      end
      b_vs = 1'b0; tick();
    end
    rnd_on = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
